// File: rtl/ext_pipe.sv
// rtl/ext_pipe.sv - registered immediate/load-data extender with 2-entry skid buffer
//
// Extends an immediate (ZERO/SIGN/LUI) or selects and extends a byte/half of a
// loaded word (LBU/LB/LHU/LH). Results pass through a main output register
// backed by one skid register, so a stalled consumer never loses a result and
// an unstalled stream runs at one result per cycle.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   flush     synchronous kill of all buffered entries (wins over everything)
//   in_valid  request present          in_ready  request accepted this cycle
//   in_op     mode (0 ZERO,1 SIGN,2 LUI,3 LBU,4 LB,5 LHU,6 LH,7 reserved)
//   in_off    byte offset within the word (load modes only)
//   in_data   immediate in low IW bits, or loaded word
//   out_valid result present           out_ready consumer takes result
//   out_data  extended result          out_err   result came from op 7

module ext_pipe #(
    parameter int DW = 32,
    parameter int IW = 16,
    localparam int OFFW = $clog2(DW / 8)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [OFFW-1:0] in_off,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic            out_err
);

    localparam logic [2:0] OP_ZERO = 3'd0;
    localparam logic [2:0] OP_SIGN = 3'd1;
    localparam logic [2:0] OP_LUI  = 3'd2;
    localparam logic [2:0] OP_LBU  = 3'd3;
    localparam logic [2:0] OP_LB   = 3'd4;
    localparam logic [2:0] OP_LHU  = 3'd5;
    localparam logic [2:0] OP_LH   = 3'd6;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t          state;
    logic [DW-1:0]   skid_data;
    logic            skid_err;

    logic [DW-1:0]   ext_data;
    logic            ext_err;
    logic [OFFW-1:0] half_off;
    logic [DW-1:0]   sh_b;
    logic [DW-1:0]   sh_h;
    logic [7:0]      sel_b;
    logic [15:0]     sel_h;
    logic            accept;
    logic            transfer;

    assign accept   = in_valid & in_ready;
    assign transfer = out_valid & out_ready;

    // Half-word selects ignore off[0]; a misaligned half offset silently
    // rounds down rather than trapping.
    assign half_off = in_off & ~OFFW'(1);
    assign sh_b     = in_data >> {in_off, 3'b000};
    assign sh_h     = in_data >> {half_off, 3'b000};
    assign sel_b    = sh_b[7:0];
    assign sel_h    = sh_h[15:0];

    always_comb begin
        ext_data = '0;
        ext_err  = 1'b0;
        case (in_op)
            OP_ZERO: ext_data = {{(DW-IW){1'b0}}, in_data[IW-1:0]};
            OP_SIGN: ext_data = {{(DW-IW){in_data[IW-1]}}, in_data[IW-1:0]};
            OP_LUI:  ext_data = {in_data[IW-1:0], {(DW-IW){1'b0}}};
            OP_LBU:  ext_data = {{(DW-8){1'b0}}, sel_b};
            OP_LB:   ext_data = {{(DW-8){sel_b[7]}}, sel_b};
            OP_LHU:  ext_data = {{(DW-16){1'b0}}, sel_h};
            OP_LH:   ext_data = {{(DW-16){sel_h[15]}}, sel_h};
            default: ext_err  = 1'b1;
        endcase
    end

    // in_ready is registered from the next state so out_ready never reaches
    // it combinationally; it is low exactly while the skid holds an entry.
    // It resets low and rises on the first edge after reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            skid_data <= '0;
            skid_err  <= 1'b0;
            in_ready  <= 1'b0;
        end else if (flush) begin
            state     <= S_EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            in_ready <= 1'b1;
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        out_data  <= ext_data;
                        out_err   <= ext_err;
                        out_valid <= 1'b1;
                        state     <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && transfer) begin
                        out_data <= ext_data;
                        out_err  <= ext_err;
                    end else if (accept) begin
                        skid_data <= ext_data;
                        skid_err  <= ext_err;
                        in_ready  <= 1'b0;
                        state     <= S_FULL;
                    end else if (transfer) begin
                        out_valid <= 1'b0;
                        state     <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (transfer) begin
                        out_data <= skid_data;
                        out_err  <= skid_err;
                        state    <= S_ONE;
                    end else begin
                        in_ready <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= S_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// tb/tb_ext_pipe.sv - table-driven and sequence checks for ext_pipe

module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [1:0]  in_off;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    int total = 0;
    int bad   = 0;
    logic [31:0] rx[$];

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  off;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[16];

    ext_pipe #(.DW(32), .IW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_off    (in_off),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Records a consumer-side transfer, then advances to 1 time unit past the edge.
    task automatic tick();
        if (!reset && out_valid && out_ready) rx.push_back(out_data);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [1:0] off, input logic [31:0] d);
        in_valid = v;
        in_op    = op;
        in_off   = off;
        in_data  = d;
    endtask

    initial begin
        vecs[0]  = '{3'd1, 2'd0, 32'h0000_8001, 32'hFFFF_8001, 1'b0};
        vecs[1]  = '{3'd0, 2'd0, 32'h0000_8001, 32'h0000_8001, 1'b0};
        vecs[2]  = '{3'd2, 2'd0, 32'h0000_1234, 32'h1234_0000, 1'b0};
        vecs[3]  = '{3'd7, 2'd2, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
        vecs[4]  = '{3'd4, 2'd3, 32'h80FF_7F01, 32'hFFFF_FF80, 1'b0};
        vecs[5]  = '{3'd3, 2'd1, 32'h80FF_7F01, 32'h0000_007F, 1'b0};
        vecs[6]  = '{3'd6, 2'd2, 32'h80FF_7F01, 32'hFFFF_80FF, 1'b0};
        vecs[7]  = '{3'd5, 2'd1, 32'h80FF_7F01, 32'h0000_7F01, 1'b0};
        vecs[8]  = '{3'd3, 2'd3, 32'h80FF_7F01, 32'h0000_0080, 1'b0};
        vecs[9]  = '{3'd4, 2'd0, 32'h80FF_7F01, 32'h0000_0001, 1'b0};
        vecs[10] = '{3'd6, 2'd3, 32'h80FF_7F01, 32'hFFFF_80FF, 1'b0};
        vecs[11] = '{3'd5, 2'd0, 32'h80FF_7F01, 32'h0000_7F01, 1'b0};
        vecs[12] = '{3'd1, 2'd0, 32'h1234_7FFF, 32'h0000_7FFF, 1'b0};
        vecs[13] = '{3'd0, 2'd0, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0};
        vecs[14] = '{3'd2, 2'd0, 32'hABCD_FFFF, 32'hFFFF_0000, 1'b0};
        vecs[15] = '{3'd4, 2'd2, 32'h80FF_7F01, 32'hFFFF_FFFF, 1'b0};

        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 3'd0, 2'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_out_err", 32'(out_err), 32'd0);
        reset = 1'b0;
        tick();
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        chk("post_reset_out_valid", 32'(out_valid), 32'd0);

        // Streaming table: one request per cycle, consumer always ready.
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].op, vecs[i].off, vecs[i].data);
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
            chk($sformatf("vec%0d_err", i), 32'(out_err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
        end
        drive(1'b0, 3'd0, 2'd0, 32'h0);
        tick();
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        // Stall: A, B, C with the consumer blocked for three cycles.
        rx.delete();
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 2'd0, 32'h0000_00A1);
        tick();
        chk("stall_a_valid", 32'(out_valid), 32'd1);
        chk("stall_a_data", out_data, 32'h0000_00A1);
        chk("stall_a_in_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 3'd0, 2'd0, 32'h0000_00B2);
        tick();
        chk("stall_b_in_ready", 32'(in_ready), 32'd0);
        chk("stall_b_hold", out_data, 32'h0000_00A1);
        drive(1'b1, 3'd0, 2'd0, 32'h0000_00C3);
        tick();
        chk("stall_c_in_ready", 32'(in_ready), 32'd0);
        chk("stall_c_hold", out_data, 32'h0000_00A1);
        out_ready = 1'b1;
        tick();
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_data_b", out_data, 32'h0000_00B2);
        tick();
        drive(1'b0, 3'd0, 2'd0, 32'hFFFF_FFFF);
        chk("release_data_c", out_data, 32'h0000_00C3);
        repeat (3) tick();
        chk("stall_rx_count", 32'(rx.size()), 32'd3);
        if (rx.size() == 3) begin
            chk("stall_rx0", rx[0], 32'h0000_00A1);
            chk("stall_rx1", rx[1], 32'h0000_00B2);
            chk("stall_rx2", rx[2], 32'h0000_00C3);
        end
        chk("stall_idle_valid", 32'(out_valid), 32'd0);

        // Flush from FULL with a request offered, then flush racing an accept.
        rx.delete();
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 2'd0, 32'h0000_8D01);
        tick();
        drive(1'b1, 3'd1, 2'd0, 32'h0000_8D02);
        tick();
        chk("flush_full_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 3'd1, 2'd0, 32'h0000_8D03);
        flush = 1'b1;
        tick();
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_out_data", out_data, 32'h0);
        chk("flush_out_err", 32'(out_err), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 3'd7, 2'd0, 32'h0000_8D04);
        tick();
        chk("flush_accept_dropped", 32'(out_valid), 32'd0);
        chk("flush_accept_err", 32'(out_err), 32'd0);
        flush = 1'b0;
        drive(1'b0, 3'd0, 2'd0, 32'h0);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("flush_rx_count", 32'(rx.size()), 32'd0);
        chk("flush_idle_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset while FULL, then recovery.
        out_ready = 1'b0;
        drive(1'b1, 3'd2, 2'd0, 32'h0000_5555);
        tick();
        drive(1'b1, 3'd7, 2'd0, 32'h0000_6666);
        tick();
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        chk("pre_reset_data", out_data, 32'h5555_0000);
        drive(1'b0, 3'd0, 2'd0, 32'h0);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset_valid", 32'(out_valid), 32'd0);
        chk("async_reset_data", out_data, 32'h0);
        chk("async_reset_err", 32'(out_err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk("recover_in_ready", 32'(in_ready), 32'd1);
        chk("recover_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        drive(1'b1, 3'd1, 2'd0, 32'h0000_FFFF);
        tick();
        drive(1'b0, 3'd0, 2'd0, 32'h0);
        chk("recover_valid", 32'(out_valid), 32'd1);
        chk("recover_data", out_data, 32'hFFFF_FFFF);
        chk("recover_err", 32'(out_err), 32'd0);
        tick();
        chk("recover_drain", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
